// File: rtl/iter_pkg.sv
// Shared types and constants for the iteration counter and its FSM.
package iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } iter_state_t;

  // Direction selectors for the DOWN parameter of iter_counter.
  localparam bit CNT_UP   = 1'b0;
  localparam bit CNT_DOWN = 1'b1;

endpackage

// File: rtl/iter_fsm.sv
// Run-control state machine for iter_counter: IDLE -> RUN -> HOLD (or
// back around RUN when auto-reloading).
module iter_fsm
  import iter_pkg::*;
#(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Load,
  input  logic        Abort,
  input  logic        at_target,
  output iter_state_t state,
  output logic        reload
);

  iter_state_t state_reg;
  iter_state_t state_next;

  // State register; asynchronous reset returns the counter to IDLE.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and reload request; Load outranks Abort, which outranks
  // the terminal transition. The terminal transition ignores En.
  always_comb begin
    state_next = state_reg;
    reload     = 1'b0;
    if ((state_reg == RUN) && at_target && AUTO_RELOAD) begin
      reload = 1'b1;
    end
    if (Load) begin
      state_next = RUN;
    end else if (Abort) begin
      state_next = IDLE;
    end else if ((state_reg == RUN) && at_target) begin
      state_next = AUTO_RELOAD ? RUN : HOLD;
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/iter_counter.sv
// Programmable iteration counter: Load latches a terminal count, En steps
// the count toward the target, K/Done flag the terminal cycle.
module iter_counter
  import iter_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter bit DOWN        = CNT_UP,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Load,
  input  logic [WIDTH-1:0] Count_In,
  input  logic             En,
  input  logic             Abort,
  output logic [WIDTH-1:0] Count,
  output logic             Busy,
  output logic             K,
  output logic             Done
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] tc_reg;
  logic [WIDTH-1:0] tc_next;
  logic [WIDTH-1:0] target;
  logic             at_target;
  logic             reload;
  iter_state_t      state;

  iter_fsm #(
    .AUTO_RELOAD(AUTO_RELOAD)
  ) u_fsm (
    .Clk       (Clk),
    .Rst       (Rst),
    .Load      (Load),
    .Abort     (Abort),
    .at_target (at_target),
    .state     (state),
    .reload    (reload)
  );

  // Terminal comparator works only on registered count and TC, so K and
  // Done have no combinational path from any input.
  always_comb begin
    target    = (DOWN == CNT_DOWN) ? '0 : tc_reg;
    at_target = (count_reg == target);
  end

  // Count/TC update; Load > Abort > reload > enabled step.
  always_comb begin
    count_next = count_reg;
    tc_next    = tc_reg;
    if (Load) begin
      tc_next    = Count_In;
      count_next = (DOWN == CNT_DOWN) ? Count_In : '0;
    end else if (Abort) begin
      count_next = '0;
    end else if (reload) begin
      count_next = (DOWN == CNT_DOWN) ? tc_reg : '0;
    end else if ((state == RUN) && !at_target && En) begin
      count_next = (DOWN == CNT_DOWN) ? (count_reg - 1'b1) : (count_reg + 1'b1);
    end
  end

  // Count and latched TC registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count_reg <= '0;
      tc_reg    <= '0;
    end else begin
      count_reg <= count_next;
      tc_reg    <= tc_next;
    end
  end

  // Output decode from registered state.
  always_comb begin
    Count = count_reg;
    Busy  = (state == RUN);
    K     = (state != IDLE) && at_target;
    Done  = (state == RUN) && at_target;
  end

endmodule

// File: tb/tb_iter_counter.sv
// Bench for iter_counter: vector table on the default build, directed
// multi-cycle sequences, and randomized traffic against a step-count model.
module tb_iter_counter;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  logic       ld0 = 0, ab0 = 0, en0 = 0;
  logic [2:0] cin0 = 0, cnt0;
  logic       busy0, k0, done0;
  logic       ld1 = 0, ab1 = 0, en1 = 0;
  logic [7:0] cin1 = 0, cnt1;
  logic       busy1, k1, done1;
  logic       ld2 = 0, ab2 = 0, en2 = 0;
  logic [2:0] cin2 = 0, cnt2;
  logic       busy2, k2, done2;

  iter_counter #(.WIDTH(3), .DOWN(1'b0), .AUTO_RELOAD(1'b0)) dut0 (
    .Clk(Clk), .Rst(Rst), .Load(ld0), .Count_In(cin0), .En(en0), .Abort(ab0),
    .Count(cnt0), .Busy(busy0), .K(k0), .Done(done0));
  iter_counter #(.WIDTH(8), .DOWN(1'b1), .AUTO_RELOAD(1'b0)) dut1 (
    .Clk(Clk), .Rst(Rst), .Load(ld1), .Count_In(cin1), .En(en1), .Abort(ab1),
    .Count(cnt1), .Busy(busy1), .K(k1), .Done(done1));
  iter_counter #(.WIDTH(3), .DOWN(1'b0), .AUTO_RELOAD(1'b1)) dut2 (
    .Clk(Clk), .Rst(Rst), .Load(ld2), .Count_In(cin2), .En(en2), .Abort(ab2),
    .Count(cnt2), .Busy(busy2), .K(k2), .Done(done2));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // Reference model: a run is described by its latched TC and the number
  // of steps taken since the start value; phase 0=idle 1=run 2=hold.
  typedef struct {
    int phase;
    int tc;
    int steps;
  } mdl_t;

  function automatic mdl_t mstep(mdl_t m, bit ld, bit ab, bit en, int cin, bit ar);
    mdl_t r = m;
    bit term = (m.phase == 1) && (m.steps == m.tc);
    if (ld) begin
      r.phase = 1; r.tc = cin; r.steps = 0;
    end else if (ab) begin
      r.phase = 0; r.steps = 0;
    end else if (term) begin
      if (ar) r.steps = 0;
      else    r.phase = 2;
    end else if (m.phase == 1 && en) begin
      r.steps = m.steps + 1;
    end
    return r;
  endfunction

  function automatic int mcount(mdl_t m, bit down);
    if (m.phase == 0) return 0;
    return down ? (m.tc - m.steps) : m.steps;
  endfunction

  task automatic mchk(input string tag, input mdl_t m, input bit down,
                      input int c, input bit b, input bit k, input bit d);
    chk({tag, "_count"}, c, mcount(m, down));
    chk({tag, "_busy"}, int'(b), int'(m.phase == 1));
    chk({tag, "_k"}, int'(k), int'(m.phase != 0 && m.steps == m.tc));
    chk({tag, "_done"}, int'(d), int'(m.phase == 1 && m.steps == m.tc));
  endtask

  typedef struct {
    logic       ld, ab, en;
    logic [2:0] cin;
    logic [2:0] cnt;
    logic       k, d, b;
  } vec_t;

  function automatic vec_t mk(bit ld, bit ab, bit en, int cin, int cnt, bit k, bit d, bit b);
    vec_t v;
    v.ld = ld; v.ab = ab; v.en = en; v.cin = 3'(cin); v.cnt = 3'(cnt);
    v.k = k; v.d = d; v.b = b;
    return v;
  endfunction

  vec_t tbl[20];
  mdl_t m0, m1, m2;

  initial begin
    // Expected outputs after the edge at which each row's inputs are sampled.
    tbl[0] = mk(1, 0, 1, 7, 0, 0, 0, 1);
    for (int i = 1; i <= 6; i++) tbl[i] = mk(0, 0, 1, 0, i, 0, 0, 1);
    tbl[7]  = mk(0, 0, 1, 0, 7, 1, 1, 1);
    tbl[8]  = mk(0, 0, 1, 0, 7, 1, 0, 0);
    tbl[9]  = mk(0, 0, 1, 0, 7, 1, 0, 0);
    tbl[10] = mk(1, 0, 0, 0, 0, 1, 1, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 1, 0, 0);
    tbl[12] = mk(1, 0, 1, 7, 0, 0, 0, 1);
    tbl[13] = mk(0, 0, 1, 0, 1, 0, 0, 1);
    tbl[14] = mk(0, 0, 1, 0, 2, 0, 0, 1);
    tbl[15] = mk(0, 0, 1, 0, 3, 0, 0, 1);
    tbl[16] = mk(0, 1, 1, 0, 0, 0, 0, 0);
    tbl[17] = mk(1, 1, 1, 7, 0, 0, 0, 1);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 1);
    tbl[19] = mk(0, 0, 1, 0, 1, 0, 0, 1);

    // Reset state.
    @(negedge Clk);
    chk("rst_count0", cnt0, 0);   chk("rst_busy0", busy0, 0);
    chk("rst_k0", k0, 0);         chk("rst_done0", done0, 0);
    chk("rst_count1", cnt1, 0);   chk("rst_k1", k1, 0);
    chk("rst_k2", k2, 0);         chk("rst_done2", done2, 0);
    Rst = 1'b0;
    tick();

    // Vector table on the default-parameter counter.
    for (int i = 0; i < 20; i++) begin
      ld0 = tbl[i].ld; ab0 = tbl[i].ab; en0 = tbl[i].en; cin0 = tbl[i].cin;
      tick();
      $display("vec %0d ld=%0b ab=%0b en=%0b cin=%0d -> count=%0d k=%0b done=%0b busy=%0b",
               i, ld0, ab0, en0, cin0, cnt0, k0, done0, busy0);
      chk($sformatf("vec%0d_count", i), cnt0, tbl[i].cnt);
      chk($sformatf("vec%0d_k", i), k0, tbl[i].k);
      chk($sformatf("vec%0d_done", i), done0, tbl[i].d);
      chk($sformatf("vec%0d_busy", i), busy0, tbl[i].b);
    end
    ld0 = 0; ab0 = 0; en0 = 0;

    // Down counter, TC=200, En toggling: terminal after 200 enabled edges.
    begin
      int enabled = 0;
      int budget = 0;
      ld1 = 1; cin1 = 8'd200; en1 = 1;
      tick();
      ld1 = 0;
      chk("down_start", cnt1, 200);
      while (!done1 && budget < 1000) begin
        en1 = 1'($urandom_range(0, 1));
        tick();
        if (en1) enabled++;
        budget++;
        if (cnt1 != 8'(200 - enabled)) chk("down_track", cnt1, 200 - enabled);
      end
      $display("down run: done after %0d cycles, %0d enabled", budget, enabled);
      chk("down_done_seen", done1, 1);
      chk("down_enabled_edges", enabled, 200);
      chk("down_final_count", cnt1, 0);
      en1 = 0;
      tick();
      chk("down_hold_busy", busy1, 0);
      chk("down_hold_k", k1, 1);
      chk("down_hold_done", done1, 0);
    end

    // Auto-reload, TC=4: Done every 5 cycles, Busy stays high.
    begin
      int bad_busy = 0;
      int dones = 0;
      ld2 = 1; cin2 = 3'd4; en2 = 1;
      tick();
      ld2 = 0;
      for (int i = 0; i < 20; i++) begin
        $display("reload cyc %0d count=%0d done=%0b busy=%0b", i, cnt2, done2, busy2);
        if (cnt2 != 3'(i % 5)) chk("reload_count", cnt2, i % 5);
        if (done2 != (i % 5 == 4)) chk("reload_done", done2, int'(i % 5 == 4));
        if (!busy2) bad_busy++;
        if (done2) dones++;
        tick();
      end
      chk("reload_busy_low_cycles", bad_busy, 0);
      chk("reload_done_count", dones, 4);
      en2 = 0;
    end

    // Count_In change mid-run is ignored; async Rst clears before the edge.
    ld0 = 1; cin0 = 3'd7; en0 = 1;
    tick();
    ld0 = 0;
    tick(); tick(); tick();
    cin0 = 3'd2;
    tick(); tick();
    chk("midrun_count", cnt0, 5);
    chk("midrun_k", k0, 0);
    #2 Rst = 1'b1;
    #1;
    $display("async reset mid-run: count=%0d busy=%0b k=%0b done=%0b", cnt0, busy0, k0, done0);
    chk("arst_count", cnt0, 0);
    chk("arst_busy", busy0, 0);
    chk("arst_k", k0, 0);
    chk("arst_done", done0, 0);
    @(negedge Clk);
    Rst = 1'b0;
    en0 = 0; cin0 = 0;
    tick();

    // Randomized traffic on all three builds against the model.
    m0 = '{0, 0, 0}; m1 = '{0, 0, 0}; m2 = '{0, 0, 0};
    for (int cyc = 0; cyc < 400; cyc++) begin
      ld0 = ($urandom_range(0, 15) == 0); ab0 = ($urandom_range(0, 23) == 0);
      en0 = 1'($urandom_range(0, 1));     cin0 = 3'($urandom);
      ld1 = ($urandom_range(0, 40) == 0); ab1 = ($urandom_range(0, 60) == 0);
      en1 = ($urandom_range(0, 3) != 0);  cin1 = 8'($urandom_range(0, 20));
      ld2 = ($urandom_range(0, 20) == 0); ab2 = ($urandom_range(0, 30) == 0);
      en2 = 1'($urandom_range(0, 1));     cin2 = 3'($urandom);
      tick();
      m0 = mstep(m0, ld0, ab0, en0, int'(cin0), 1'b0);
      m1 = mstep(m1, ld1, ab1, en1, int'(cin1), 1'b0);
      m2 = mstep(m2, ld2, ab2, en2, int'(cin2), 1'b1);
      $display("rnd %0d c0=%0d c1=%0d c2=%0d d=%0b%0b%0b", cyc, cnt0, cnt1, cnt2, done0, done1, done2);
      mchk("rnd0", m0, 1'b0, int'(cnt0), busy0, k0, done0);
      mchk("rnd1", m1, 1'b1, int'(cnt1), busy1, k1, done1);
      mchk("rnd2", m2, 1'b0, int'(cnt2), busy2, k2, done2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iter_counter.md
# iter_counter

Parametrised iteration counter for the shift-add multiplier datapath and other multi-cycle sequential operators. A start pulse loads a programmable terminal count, enable-gated steps advance the count, and the block flags completion with a level (`K`) and a one-cycle `Done` pulse. It supports up/down counting, abort, and auto-reload. It supersedes the fixed 3-bit, count-to-7 iteration counter; `WIDTH=3`, `Count_In=7`, `En=1` reproduces that behaviour.

## Interface
- `WIDTH`, default 3: count and terminal-count width in bits (≥1).
- `DOWN`, default 0: 0 counts 0→TC; 1 counts TC→0.
- `AUTO_RELOAD`, default 0: 1 restarts the count automatically after each terminal cycle (periodic mode).

Ports:
- `Clk`  in  1  rising-edge clock; the only clock.
- `Rst`  in  1  asynchronous, active-high reset.
- `Load`  in  1  synchronous start; sampled on `Clk`; restarts even when busy.
- `Count_In`  in  WIDTH  terminal count TC; latched only when `Load`=1.
- `En`  in  1  step enable; honoured only in RUN.
- `Abort`  in  1  synchronous cancel; returns to IDLE.
- `Count`  out  WIDTH  current count register.
- `Busy`  out  1  high in RUN.
- `K`  out  1  terminal level: high when state≠IDLE and Count equals the target.
- `Done`  out  1  one-cycle pulse on the first terminal cycle of each run/period.

## Operation
- States:
  - IDLE: reset state.
  - RUN: counting.
  - HOLD: terminal reached, non-reload mode only.
- Target definition:
  - Target = TC when `DOWN`=0; target = 0 when `DOWN`=1.
  - Start value = 0 when `DOWN`=0; start value = TC when `DOWN`=1.
- Reset (`Rst`=1, async): state IDLE, `Count`=0, latched TC=0, `Busy`=0, `K`=0, `Done`=0.
- `Load`=1 at an edge, in any state:
  - TC ← `Count_In`; `Count` ← start value; state ← RUN.
- RUN, `Count` ≠ target, `En`=1: `Count` moves one step toward the target.
- RUN, `Count` ≠ target, `En`=0: hold.
- RUN, `Count` = target:
  - `K`=1 and `Done`=1 combinationally in that cycle.
  - Next edge, `AUTO_RELOAD`=0: state ← HOLD, `Count` holds.
  - Next edge, `AUTO_RELOAD`=1: `Count` ← start value, state stays RUN.
  - Neither transition depends on `En`.
- HOLD: `K`=1, `Done`=0, `Busy`=0; stays until `Load`, `Abort` or `Rst`.
- `Abort`=1 at an edge, `Load`=0: state ← IDLE, `Count` ← 0; no `Done` is generated.
- Priority: `Rst` > `Load` > `Abort` > `En`.
- Arithmetic is modulo 2^WIDTH. The count never passes the target, so no wrap occurs in normal operation.
- TC = 0: the target is reached in the first RUN cycle. `Done` pulses with no `En` needed.
- TC = 2^WIDTH−1 is legal; the full range is usable.

## Timing
- Load-to-terminal latency: `Load` at edge 0 with TC=N and `En` held high.
  - `Count`=0 after edge 0 (`DOWN`=0).
  - `K`/`Done` asserted in the cycle after edge N.
  - HOLD after edge N+1.
- `En` low for M cycles delays the terminal cycle by exactly M cycles.
- `Busy` is registered state decode. `K` and `Done` are combinational from registered state, `Count` and TC only, with no input-to-output path.
- Auto-reload period = TC+1 cycles with `En` high; `Done` pulses once per period.
- `Rst` mid-run: outputs clear immediately (asynchronous), not at the next edge.
- `Load` arriving in the terminal cycle restarts the run. `Done` is still visible in that cycle.

## Structure
- Shared package `iter_pkg` holds the state enum (IDLE/RUN/HOLD) and the direction constants `CNT_UP`/`CNT_DOWN`.
- One natural sub-module, `iter_fsm`: the state register plus next-state logic. It takes `at_target`, `Load` and `Abort` as inputs and drives the state and `reload` outputs.
- The count and TC registers plus the comparator stay in the top level.

## Test plan
- Default parameters, `Load` with `Count_In`=7, `En`=1 → `Count` reads 0..7; `K`=`Done`=1 in the cycle after edge 7; edge 8 enters HOLD with `K`=1, `Done`=0, `Busy`=0.
- `WIDTH`=8, `DOWN`=1, `Count_In`=200, `En` toggled 50% → `Count` goes 200→0; `Done` after exactly 200 enabled edges plus the load edge.
- `Count_In`=0 → `Done` in the first cycle after `Load`; `Count`=0; then HOLD.
- `AUTO_RELOAD`=1, `Count_In`=4, `En`=1 → `Done` every 5 cycles for ≥3 periods; `Busy` stays 1.
- `Abort` at `Count`=3, TC=7 → IDLE with `Count`=0 and no `Done`. `Load` and `Abort` on the same edge → the run restarts.
- `Rst` asserted between edges mid-run at `Count`=5 → all outputs 0 before the next edge; `Count_In` changes during RUN have no effect.
